// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the accelerator FSM state encodings, the default timeout, the
// register-index type and the load-use match helper used by the top level.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W              = 5;
    localparam int unsigned PERF_W             = 32;
    localparam int unsigned HZ_ACC_TIMEOUT_DEF = 1024;

    // Accelerator handshake FSM state encodings
    localparam logic [1:0] HZ_IDLE = 2'd0;
    localparam logic [1:0] HZ_REQ  = 2'd1;
    localparam logic [1:0] HZ_WAIT = 2'd2;
    localparam logic [1:0] HZ_DONE = 2'd3;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Stall/bubble controls that the top actively computes
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic bubble_id;
        logic bubble_ex;
        logic bubble_mem;
    } pipe_ctrl_t;

    // True when the ID instruction reads the register a load in EX is producing
    function automatic logic load_use_hit(
        input logic     mem_read,
        input reg_idx_t rd,
        input reg_idx_t rs1,
        input reg_idx_t rs2,
        input logic     uses_rs1,
        input logic     uses_rs2
    );
        return mem_read && (rd != '0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath and the hazard controller.
// master: datapath/accelerator side (drives ID/EX fields and acc_ready/acc_done).
// slave : hazard controller (drives acc_req, acc_err, stall/bubble and perf counters).
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    reg_idx_t            rs1_id;
    reg_idx_t            rs2_id;
    logic                uses_rs1_id;
    logic                uses_rs2_id;
    reg_idx_t            rd_ex;
    logic                mem_read_ex;
    logic                branch_taken_ex;
    logic                accel_instr_ex;
    logic                acc_ready;
    logic                acc_done;

    logic                acc_req;
    logic                acc_err;
    logic                stall_if;
    logic                stall_id;
    logic                stall_ex;
    logic                stall_mem;
    logic                stall_wb;
    logic                bubble_id;
    logic                bubble_ex;
    logic                bubble_mem;
    logic                bubble_wb;
    logic [PERF_W-1:0]   perf_stall_cyc;
    logic [PERF_W-1:0]   perf_flush_cnt;
    logic [PERF_W-1:0]   perf_acc_cyc;

    modport master (
        output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, rd_ex, mem_read_ex,
               branch_taken_ex, accel_instr_ex, acc_ready, acc_done,
        input  acc_req, acc_err, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
               bubble_id, bubble_ex, bubble_mem, bubble_wb,
               perf_stall_cyc, perf_flush_cnt, perf_acc_cyc
    );

    modport slave (
        input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, rd_ex, mem_read_ex,
               branch_taken_ex, accel_instr_ex, acc_ready, acc_done,
        output acc_req, acc_err, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
               bubble_id, bubble_ex, bubble_mem, bubble_wb,
               perf_stall_cyc, perf_flush_cnt, perf_acc_cyc
    );

endinterface

// File: rtl/hazard_acc_fsm.sv
// Accelerator req/ready/done handshake FSM with WAIT timeout.
// Ports: clk, rst_n (async active-low); accel_instr_i, acc_ready_i, acc_done_i in;
//        acc_req_o (combinational), acc_err_o (registered, sticky),
//        acc_stall_o (hold IF/ID/EX), acc_busy_o (state is REQ or WAIT).
module hazard_acc_fsm
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned ACC_TIMEOUT = HZ_ACC_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accel_instr_i,
    input  logic acc_ready_i,
    input  logic acc_done_i,
    output logic acc_req_o,
    output logic acc_err_o,
    output logic acc_stall_o,
    output logic acc_busy_o
);

    localparam int unsigned     CNT_W   = $clog2(ACC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;

    // State, timeout counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Saturating count of WAIT cycles including the current one
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        acc_req_o   = 1'b0;
        acc_stall_o = 1'b0;
        acc_busy_o  = 1'b0;
        case (state_q)
            HZ_IDLE: begin
                if (accel_instr_i) begin
                    acc_req_o   = 1'b1;
                    acc_stall_o = 1'b1;
                    cnt_d       = '0;
                    state_d     = HZ_REQ;
                end
            end
            HZ_REQ: begin
                acc_req_o   = 1'b1;
                acc_stall_o = 1'b1;
                acc_busy_o  = 1'b1;
                if (acc_ready_i) begin
                    state_d = acc_done_i ? HZ_DONE : HZ_WAIT;
                end
            end
            HZ_WAIT: begin
                acc_stall_o = 1'b1;
                acc_busy_o  = 1'b1;
                cnt_d       = cnt_inc;
                if (acc_done_i) begin
                    state_d = HZ_DONE;
                end else if (cnt_inc == CNT_MAX) begin
                    // Abandon the result; the instruction still retires
                    err_d   = 1'b1;
                    state_d = HZ_DONE;
                end
            end
            HZ_DONE: begin
                // Release cycle: the same instruction is still in EX, ignore it
                state_d = HZ_IDLE;
            end
            default: begin
                state_d = HZ_IDLE;
            end
        endcase
    end

    assign acc_err_o = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken branch and accelerator stalls.
// Ports: clk, rst_n (async active-low), hz (hazard_ctrl_if.slave) carrying the
//        ID/EX fields, accelerator handshake and all stall/bubble outputs.
// Optional: define HAZARD_PERF_CNT_EN to build the 32-bit perf counters;
//           otherwise perf_* outputs are tied to zero.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned ACC_TIMEOUT = HZ_ACC_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    logic       acc_stall;
    logic       acc_busy;
    logic       load_use;
    pipe_ctrl_t ctrl;

    hazard_acc_fsm #(
        .ACC_TIMEOUT (ACC_TIMEOUT)
    ) u_acc_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .accel_instr_i (hz.accel_instr_ex),
        .acc_ready_i   (hz.acc_ready),
        .acc_done_i    (hz.acc_done),
        .acc_req_o     (hz.acc_req),
        .acc_err_o     (hz.acc_err),
        .acc_stall_o   (acc_stall),
        .acc_busy_o    (acc_busy)
    );

    assign load_use = load_use_hit(hz.mem_read_ex, hz.rd_ex, hz.rs1_id, hz.rs2_id,
                                   hz.uses_rs1_id, hz.uses_rs2_id);

    // Priority: accelerator hold, then branch flush, then load-use interlock
    always_comb begin
        ctrl = '0;
        if (acc_stall) begin
            ctrl.stall_if   = 1'b1;
            ctrl.stall_id   = 1'b1;
            ctrl.stall_ex   = 1'b1;
            ctrl.bubble_mem = 1'b1;
        end else if (hz.branch_taken_ex) begin
            ctrl.bubble_id  = 1'b1;
            ctrl.bubble_ex  = 1'b1;
        end else if (load_use) begin
            ctrl.stall_if   = 1'b1;
            ctrl.stall_id   = 1'b1;
            ctrl.bubble_ex  = 1'b1;
        end
    end

    assign hz.stall_if   = ctrl.stall_if;
    assign hz.stall_id   = ctrl.stall_id;
    assign hz.stall_ex   = ctrl.stall_ex;
    assign hz.stall_mem  = 1'b0;
    assign hz.stall_wb   = 1'b0;
    assign hz.bubble_id  = ctrl.bubble_id;
    assign hz.bubble_ex  = ctrl.bubble_ex;
    assign hz.bubble_mem = ctrl.bubble_mem;
    assign hz.bubble_wb  = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_q, perf_flush_q, perf_acc_q;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_acc_q   <= '0;
        end else begin
            if (ctrl.stall_id) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
            if (ctrl.bubble_id) begin
                perf_flush_q <= perf_flush_q + PERF_W'(1);
            end
            if (acc_busy) begin
                perf_acc_q <= perf_acc_q + PERF_W'(1);
            end
        end
    end

    assign hz.perf_stall_cyc = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
    assign hz.perf_acc_cyc   = perf_acc_q;
`else
    logic unused_acc_busy;
    assign unused_acc_busy   = acc_busy;
    assign hz.perf_stall_cyc = '0;
    assign hz.perf_flush_cnt = '0;
    assign hz.perf_acc_cyc   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.ACC_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int checks = 0;
    int errors = 0;

    // Model: where the accelerator instruction is in its life
    bit          m_pending;   // request issued, not yet accepted
    bit          m_accepted;  // accepted, waiting for a result
    bit          m_release;   // this cycle lets the instruction leave EX
    bit          m_err;
    int          m_waited;
    logic [31:0] m_perf_stall, m_perf_flush, m_perf_acc;

    // Expected outputs for the current cycle
    bit e_req, e_hold, e_busy, e_flush;
    bit e_sif, e_sid, e_sex, e_bid, e_bex, e_bmem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_accepted = 0; m_release = 0; m_err = 0; m_waited = 0;
        m_perf_stall = '0; m_perf_flush = '0; m_perf_acc = '0;
    endtask

    task automatic model_eval();
        bit lu, br;
        lu = hz.mem_read_ex && (hz.rd_ex != 0) &&
             ((hz.uses_rs1_id && hz.rs1_id == hz.rd_ex) ||
              (hz.uses_rs2_id && hz.rs2_id == hz.rd_ex));
        br = hz.branch_taken_ex;
        e_busy = !m_release && (m_pending || m_accepted);
        e_hold = !m_release && (m_pending || m_accepted || hz.accel_instr_ex);
        e_req  = !m_release && !m_accepted && (m_pending || hz.accel_instr_ex);
        {e_sif, e_sid, e_sex, e_bid, e_bex, e_bmem} = '0;
        if (e_hold) begin
            e_sif = 1; e_sid = 1; e_sex = 1; e_bmem = 1;
        end else if (br) begin
            e_bid = 1; e_bex = 1;
        end else if (lu) begin
            e_sif = 1; e_sid = 1; e_bex = 1;
        end
        e_flush = !e_hold && br;
    endtask

    task automatic model_check();
        model_eval();
        chk("acc_req",    hz.acc_req,    e_req);
        chk("acc_err",    hz.acc_err,    m_err);
        chk("stall_if",   hz.stall_if,   e_sif);
        chk("stall_id",   hz.stall_id,   e_sid);
        chk("stall_ex",   hz.stall_ex,   e_sex);
        chk("stall_mem",  hz.stall_mem,  0);
        chk("stall_wb",   hz.stall_wb,   0);
        chk("bubble_id",  hz.bubble_id,  e_bid);
        chk("bubble_ex",  hz.bubble_ex,  e_bex);
        chk("bubble_mem", hz.bubble_mem, e_bmem);
        chk("bubble_wb",  hz.bubble_wb,  0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_cyc", hz.perf_stall_cyc, m_perf_stall);
        chk("perf_flush_cnt", hz.perf_flush_cnt, m_perf_flush);
        chk("perf_acc_cyc",   hz.perf_acc_cyc,   m_perf_acc);
`else
        chk("perf_stall_cyc", hz.perf_stall_cyc, 0);
        chk("perf_flush_cnt", hz.perf_flush_cnt, 0);
        chk("perf_acc_cyc",   hz.perf_acc_cyc,   0);
`endif
    endtask

    task automatic model_update();
        model_eval();
        m_perf_stall += 32'(e_sid);
        m_perf_flush += 32'(e_flush);
        m_perf_acc   += 32'(e_busy);
        if (m_release) begin
            m_release = 0;
        end else if (m_accepted) begin
            m_waited++;
            if (hz.acc_done) begin
                m_accepted = 0; m_release = 1;
            end else if (m_waited >= int'(TMO)) begin
                m_err = 1; m_accepted = 0; m_release = 1;
            end
        end else if (m_pending) begin
            if (hz.acc_ready) begin
                m_pending = 0;
                if (hz.acc_done) m_release = 1;
                else begin m_accepted = 1; m_waited = 0; end
            end
        end else if (hz.accel_instr_ex) begin
            m_pending = 1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_update();
        else model_reset();
        #1;
    endtask

    task automatic zero_inputs();
        hz.rs1_id = '0; hz.rs2_id = '0; hz.rd_ex = '0;
        hz.uses_rs1_id = 0; hz.uses_rs2_id = 0; hz.mem_read_ex = 0;
        hz.branch_taken_ex = 0; hz.accel_instr_ex = 0;
        hz.acc_ready = 0; hz.acc_done = 0;
    endtask

    task automatic rand_inputs(input int done_pct);
        hz.rs1_id          = 5'($urandom_range(0, 7));
        hz.rs2_id          = 5'($urandom_range(0, 7));
        hz.rd_ex           = 5'($urandom_range(0, 7));
        hz.uses_rs1_id     = 1'($urandom_range(0, 1));
        hz.uses_rs2_id     = 1'($urandom_range(0, 1));
        hz.mem_read_ex     = ($urandom_range(0, 99) < 50);
        hz.branch_taken_ex = ($urandom_range(0, 99) < 20);
        hz.accel_instr_ex  = ($urandom_range(0, 99) < 30);
        hz.acc_ready       = ($urandom_range(0, 99) < 40);
        hz.acc_done        = ($urandom_range(0, 99) < done_pct);
    endtask

    task automatic do_reset();
        zero_inputs();
        rst_n = 0;
        model_reset();
        sample();
        chk("rst_acc_err", hz.acc_err, 0);
        chk("rst_stall_id", hz.stall_id, 0);
        advance();
        advance();
        rst_n = 1;
    endtask

    initial begin
        int hs;
        rst_n = 0;
        zero_inputs();
        model_reset();
        do_reset();

        // 1: lw x5 in EX, add x6,x5,x1 in ID
        hz.mem_read_ex = 1; hz.rd_ex = 5'd5;
        hz.rs1_id = 5'd5; hz.uses_rs1_id = 1; hz.rs2_id = 5'd1; hz.uses_rs2_id = 1;
        sample();
        chk("t1_stall_if", hz.stall_if, 1);
        chk("t1_stall_id", hz.stall_id, 1);
        chk("t1_bubble_ex", hz.bubble_ex, 1);
        chk("t1_stall_ex", hz.stall_ex, 0);
        advance();
        hz.mem_read_ex = 0;
        sample();
        chk("t1_after_stall_id", hz.stall_id, 0);
        chk("t1_after_bubble_ex", hz.bubble_ex, 0);
        advance();

        // 2: x0 destination, and an unused rs2 match
        hz.mem_read_ex = 1; hz.rd_ex = 5'd0; hz.rs1_id = 5'd0; hz.uses_rs1_id = 1;
        sample();
        chk("t2_x0_stall_id", hz.stall_id, 0);
        advance();
        hz.rd_ex = 5'd5; hz.rs1_id = 5'd1; hz.rs2_id = 5'd5; hz.uses_rs2_id = 0;
        sample();
        chk("t2_unused_rs2_stall_id", hz.stall_id, 0);
        advance();

        // 3: branch together with a load-use match
        hz.uses_rs2_id = 1; hz.branch_taken_ex = 1;
        sample();
        chk("t3_bubble_id", hz.bubble_id, 1);
        chk("t3_bubble_ex", hz.bubble_ex, 1);
        chk("t3_stall_id", hz.stall_id, 0);
        chk("t3_stall_if", hz.stall_if, 0);
        advance();
        zero_inputs();

        // 4: ready at cycle 2, done at cycle 6
        for (int c = 0; c <= 8; c++) begin
            hz.accel_instr_ex = (c <= 7);
            hz.acc_ready = (c == 2);
            hz.acc_done = (c == 6);
            sample();
            chk("t4_stall_ex", hz.stall_ex, (c <= 6));
            chk("t4_bubble_mem", hz.bubble_mem, (c <= 6));
            chk("t4_acc_req", hz.acc_req, (c <= 2));
            advance();
        end
        zero_inputs();

        // 5: ready and done together in REQ
        hs = 0;
        for (int c = 0; c <= 3; c++) begin
            hz.accel_instr_ex = (c <= 2);
            hz.acc_ready = (c == 1);
            hz.acc_done = (c == 1);
            sample();
            chk("t5_stall_ex", hz.stall_ex, (c <= 1));
            if (hz.acc_req && hz.acc_ready) hs++;
            advance();
        end
        chk("t5_handshakes", 32'(hs), 1);
        zero_inputs();

        // 6: timeout after 8 WAIT cycles, sticky until reset
        for (int c = 0; c <= 14; c++) begin
            hz.accel_instr_ex = (c <= 10);
            hz.acc_ready = (c == 1);
            hz.acc_done = 0;
            sample();
            chk("t6_stall_ex", hz.stall_ex, (c <= 9));
            chk("t6_acc_err", hz.acc_err, (c >= 10));
            advance();
        end
        do_reset();
        chk("t6_err_cleared", hz.acc_err, 0);

        // Reset in the middle of a handshake drops acc_req at once
        hz.accel_instr_ex = 1;
        sample();
        advance();
        sample();
        chk("rm_acc_req_before", hz.acc_req, 1);
        advance();
        hz.accel_instr_ex = 0;
        rst_n = 0;
        #1;
        chk("rm_acc_req_async", hz.acc_req, 0);
        chk("rm_stall_ex_async", hz.stall_ex, 0);
        model_reset();
        advance();
        rst_n = 1;

        // Randomized traffic, alternating fast and slow accelerator
        for (int seg = 0; seg < 16; seg++) begin
            int done_pct;
            done_pct = (seg % 2 == 0) ? 35 : 3;
            for (int c = 0; c < 200; c++) begin
                rand_inputs(done_pct);
                if ($urandom_range(0, 499) == 0) begin
                    rst_n = 0;
                    model_reset();
                end else begin
                    rst_n = 1;
                end
                sample();
                advance();
            end
        end
        rst_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
